// File: rtl/regfile_pkg.sv
// Shared register-file constants and types.
// Provides the register count, index width and index type.
package regfile_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (request vector), ptr (highest-priority slot), en (grant
// enable) -> grant (one-hot or zero), winner (binary), any_req.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  int unsigned pos;
  logic        found;

  // Scan from ptr upward with wrap; NUM_REQ need not be a power of two,
  // so the wrap is an explicit subtract rather than bit truncation.
  always_comb begin
    pos    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(unsigned'(ptr)) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[pos]) begin
        found  = 1'b1;
        winner = ID_W'(pos);
      end
    end
  end

  always_comb begin
    grant   = '0;
    any_req = found;
    if (found && en) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among requesters.
// Ports: clk, rst (sync, active-high); req_valid/req_idx/req_ready per
// requester; mux_sel/mux_data to the shared read mux; rsp_valid/rsp_ready
// handshake with rsp_data, rsp_id and rsp_idx of the registered response.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter  int WIDTH   = 64,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  reg_idx_t           req_idx [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output reg_idx_t           mux_sel,
  input  logic [WIDTH-1:0]   mux_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  output reg_idx_t           rsp_idx
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            any_req;
  logic            can_accept;
  logic            accept;

  // Single-entry buffer: refill allowed in the cycle it drains.
  assign can_accept = !rsp_valid || rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (can_accept && !rst),
    .grant   (req_ready),
    .winner  (winner),
    .any_req (any_req)
  );

  assign accept  = |req_ready;
  assign mux_sel = any_req ? req_idx[winner] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_idx   <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= mux_data;
      rsp_id    <= winner;
      rsp_idx   <= req_idx[winner];
      rr_ptr    <= (winner == ID_W'(NUM_REQ - 1)) ? '0
                                                  : winner + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter.
// A reference arbiter model predicts grants and queues expected responses.
module tb_regfile_read_arbiter;
  import regfile_pkg::*;

  localparam int WIDTH   = 64;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req_valid;
  reg_idx_t           req_idx [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  reg_idx_t           mux_sel;
  logic [WIDTH-1:0]   mux_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic [ID_W-1:0]    rsp_id;
  reg_idx_t           rsp_idx;

  logic [WIDTH-1:0]   regs [NUM_REGS];

  assign mux_data = regs[mux_sel];

  always #5 clk = ~clk;

  regfile_read_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_idx   (rsp_idx)
  );

  typedef struct packed {
    logic [ID_W-1:0]  id;
    reg_idx_t         idx;
    logic [WIDTH-1:0] data;
  } rsp_t;

  rsp_t sb [$];
  rsp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ptr   = 0;
  bit   m_valid = 1'b0;
  int   last_w  = -1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check combinational outputs at negedge, then the
  // registered response just after the rising edge.
  task automatic step();
    int               w;
    bit               acc;
    logic [NUM_REQ-1:0] g;
    rsp_t             e;
    @(negedge clk);
    w = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i = (m_ptr + k) % NUM_REQ;
      if (w < 0 && req_valid[i]) w = i;
    end
    g   = '0;
    acc = 1'b0;
    if (!rst && w >= 0 && (!m_valid || rsp_ready)) begin
      g[w] = 1'b1;
      acc  = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(g));
    if (w >= 0) chk("mux_sel", 64'(mux_sel), 64'(req_idx[w]));
    else        chk("mux_sel_idle", 64'(mux_sel), 64'd0);
    last_w = acc ? w : -1;
    if (acc) begin
      e.id   = ID_W'(w);
      e.idx  = req_idx[w];
      e.data = regs[req_idx[w]];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sb.delete();
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_data", rsp_data, 64'd0);
      chk("rst_id", 64'(rsp_id), 64'd0);
      chk("rst_idx", 64'(rsp_idx), 64'd0);
    end else if (acc) begin
      m_ptr   = (w + 1) % NUM_REQ;
      m_valid = 1'b1;
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      cur = sb.pop_front();
      chk("rsp_id", 64'(rsp_id), 64'(cur.id));
      chk("rsp_idx", 64'(rsp_idx), 64'(cur.idx));
      chk("rsp_data", rsp_data, cur.data);
    end else begin
      if (rsp_ready) m_valid = 1'b0;
      chk("rsp_valid_hold", 64'(rsp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("hold_id", 64'(rsp_id), 64'(cur.id));
        chk("hold_idx", 64'(rsp_idx), 64'(cur.idx));
        chk("hold_data", rsp_data, cur.data);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = {$urandom, $urandom};
    regs[7]   = 64'hDEAD;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) req_idx[i] = '0;
    #1;
    step();
    step();
    rst = 1'b0;

    // Single request after reset
    req_valid  = 4'b0100;
    req_idx[2] = 5'd7;
    step();
    chk("t1_winner", 64'(last_w), 64'd2);
    chk("t1_data", rsp_data, 64'hDEAD);
    chk("t1_id", 64'(rsp_id), 64'd2);
    req_valid = '0;
    step();

    // Fairness from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_idx[i] = reg_idx_t'(i * 3 + 1);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fair_winner", 64'(last_w), 64'(i % NUM_REQ));
    end

    // Back-pressure
    req_valid = '0;
    step();
    rsp_ready  = 1'b0;
    req_valid  = 4'b0100;
    req_idx[2] = 5'd7;
    step();
    req_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_id", 64'(rsp_id), 64'd2);
      chk("bp_data", rsp_data, 64'hDEAD);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_grant", 64'(last_w), 64'd0);
    chk("bp_new_id", 64'(rsp_id), 64'd0);
    req_valid = '0;
    step();

    // Wrap-around
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1001;
    step();
    chk("wrap_first", 64'(last_w), 64'd3);
    step();
    chk("wrap_second", 64'(last_w), 64'd0);
    req_valid = '0;
    step();

    // Reset mid-operation
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    step();
    chk("mid_pending", 64'(rsp_valid), 64'd1);
    rst       = 1'b1;
    req_valid = 4'b1111;
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    step();
    chk("post_rst_winner", 64'(last_w), 64'd1);

    // Idle: drains, pointer unchanged
    req_valid = '0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_valid", 64'(rsp_valid), 64'd0);
    chk("idle_sel", 64'(mux_sel), 64'd0);
    req_valid = 4'b1111;
    step();
    chk("idle_ptr", 64'(last_w), 64'd2);
    req_valid = '0;
    step();

    // Random traffic; requests held until accepted
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          req_valid[i] = 1'b1;
          req_idx[i]   = reg_idx_t'($urandom_range(NUM_REGS - 1, 0));
        end
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      step();
      if (last_w >= 0) req_valid[last_w] = 1'b0;
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
